hashtable_access_arbiter: RTL and testbench
===========================================

Name: hashtable_access_arbiter

Overview:
- Sits in front of one single-port segment hash table: 65536 x 12 bit block RAM, synchronous read, `we`-selected read/write.
- Shares the table between two requesters:
  - the lookup pipeline (read-only, tagged);
  - the rule-update engine (write-only).
- Grants at most one access per cycle. Update has priority, bounded by a lookup anti-starvation limit.
- Returns lookup results one cycle after grant, with the requester's tag.

Parameters:
- ADDR_W, 16, hash table address width (2^ADDR_W entries)
- DATA_W, 12, entry width: bits [10:0] segment index, bit [11] small/big segment indicator
- TAG_W, 4, lookup tag width, echoed with the response
- STARVE_LIMIT, 4, max consecutive cycles a valid lookup may lose to updates (1..15)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- lk_valid  in  1  lookup request valid
- lk_ready  out  1  lookup request accepted this cycle
- lk_addr  in  ADDR_W  lookup address
- lk_tag  in  TAG_W  lookup tag
- rsp_valid  out  1  lookup response valid
- rsp_data  out  DATA_W  table entry read
- rsp_tag  out  TAG_W  tag of the answered lookup
- up_valid  in  1  update write request valid
- up_ready  out  1  update accepted (written) this cycle
- up_addr  in  ADDR_W  update address
- up_data  in  DATA_W  new entry
- mem_we  out  1  RAM write enable (1 = write, 0 = read)
- mem_addr  out  ADDR_W  RAM address
- mem_din  out  DATA_W  RAM write data
- mem_dout  in  DATA_W  RAM registered read data (valid cycle after read address)
- upd_count  out  16  number of accepted updates, saturating at 0xFFFF

Behaviour:
Handshakes:
- A transfer occurs when valid && ready.
- Both ready outputs are combinational from the valids, starve_cnt and rst.
- Requesters hold addr, data and tag stable while valid && !ready.

Grant per cycle (rst=0):
- No valid: no grant, mem_we=0, mem_addr holds its previous value (registered hold of the last address).
- lk_valid only: grant lookup.
- up_valid only: grant update.
- Both valid:
  - starve_cnt < STARVE_LIMIT: grant update;
  - starve_cnt == STARVE_LIMIT: grant lookup.

Starvation counter (starve_cnt, 4 bits):
- Increments when lk_valid && !lk_ready.
- Clears when lk_ready or !lk_valid.
- Never exceeds STARVE_LIMIT.

RAM drive:
- Lookup grant: mem_we=0, mem_addr=lk_addr.
- Update grant: mem_we=1, mem_addr=up_addr, mem_din=up_data.
- mem_din = up_data at all times.

Response path:
- Lookup granted in cycle N gives rsp_valid=1 in cycle N+1.
- rsp_data = mem_dout (combinational pass-through in N+1).
- rsp_tag = lk_tag registered at N.
- Back-to-back lookups give back-to-back responses. There is no response backpressure; the consumer must always accept.

Hazards:
- A lookup in N followed by an update to the same address in N+1 returns the old entry.
- An update in N followed by a lookup to the same address in N+1 returns the new entry.
- No bypass logic is required; single-port ordering gives this.

upd_count:
- +1 per accepted update, saturates at 0xFFFF.
- Not cleared except by rst.

Reset (rst=1 at a clock edge):
- rsp_valid=0, rsp_tag=0, starve_cnt=0, upd_count=0, mem_addr register=0.
- While rst=1: lk_ready=0, up_ready=0, mem_we=0.
- rst mid-operation: a response due the next cycle is dropped (rsp_valid=0 after reset); no write is issued during the reset cycle.

Test Plan:
1. Reset with lk_valid=up_valid=1 -> lk_ready=up_ready=mem_we=0 throughout; after release rsp_valid=0, upd_count=0.
2. Update addr 0x0010 data 0x8A5 at cycle N, lookup addr 0x0010 tag 3 at N+1 -> rsp_valid at N+2, rsp_data=0x8A5, rsp_tag=3, upd_count=1.
3. Lookups on 4 consecutive cycles, tags 0..3, addrs preloaded 0x001..0x004 -> rsp_valid high 4 consecutive cycles with matching data/tag order.
4. lk_valid and up_valid held high continuously, STARVE_LIMIT=4 -> grants repeat U,U,U,U,L; starve_cnt peaks at 4 then clears.
5. Lookup addr 0x0020 (old 0x123) at N, update addr 0x0020 to 0x7FF at N+1 -> response data 0x123; a later lookup returns 0x7FF.
6. Preload upd_count near saturation via 65536 updates -> upd_count stays 0xFFFF; assert rst mid-lookup -> rsp_valid=0 next cycle.

Source files
------------

// File: rtl/hashtable_access_arbiter.sv
// hashtable_access_arbiter
//
// Shares one single-port, synchronous-read hash table RAM between the lookup
// pipeline (read-only, tagged) and the rule-update engine (write-only).
// At most one access is granted per cycle. Updates normally win, but a
// lookup that has already lost STARVE_LIMIT consecutive cycles wins the
// next one. A lookup result comes back one cycle after its grant, carrying
// the tag the lookup was issued with.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   lk_valid_i/lk_ready_o   lookup request handshake
//   lk_addr_i, lk_tag_i     lookup address and tag
//   rsp_valid_o             lookup response valid (no backpressure)
//   rsp_data_o, rsp_tag_o   table entry read and tag of the answered lookup
//   up_valid_i/up_ready_o   update request handshake (ready = written)
//   up_addr_i, up_data_i    update address and new entry
//   mem_we_o                RAM write enable (1 = write, 0 = read)
//   mem_addr_o, mem_din_o   RAM address and write data
//   mem_dout_i              RAM registered read data
//   upd_count_o             accepted updates, saturating at 0xFFFF
module hashtable_access_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 12,
  parameter int TAG_W        = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              lk_valid_i,
  output logic              lk_ready_o,
  input  logic [ADDR_W-1:0] lk_addr_i,
  input  logic [TAG_W-1:0]  lk_tag_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic [TAG_W-1:0]  rsp_tag_o,
  input  logic              up_valid_i,
  output logic              up_ready_o,
  input  logic [ADDR_W-1:0] up_addr_i,
  input  logic [DATA_W-1:0] up_data_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_din_o,
  input  logic [DATA_W-1:0] mem_dout_i,
  output logic [15:0]       upd_count_o
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]        starve_q, starve_d;
  logic [ADDR_W-1:0] addr_q;
  logic              rsp_valid_q;
  logic [TAG_W-1:0]  rsp_tag_q;
  logic [15:0]       upd_count_q, upd_count_d;
  logic              lk_grant, up_grant;

  always_comb begin
    lk_grant    = 1'b0;
    up_grant    = 1'b0;
    starve_d    = '0;
    upd_count_d = upd_count_q;

    if (!rst_i) begin
      // A starved lookup is the only thing that can beat a pending update.
      if (up_valid_i && !(lk_valid_i && (starve_q == LIMIT))) begin
        up_grant = 1'b1;
      end else if (lk_valid_i) begin
        lk_grant = 1'b1;
      end
    end

    if (lk_valid_i && !lk_grant && (starve_q != LIMIT)) begin
      starve_d = starve_q + 4'd1;
    end

    if (up_grant && (upd_count_q != 16'hFFFF)) begin
      upd_count_d = upd_count_q + 16'd1;
    end
  end

  // Idle cycles keep the RAM address where it was so the read port does not
  // toggle needlessly.
  always_comb begin
    if (lk_grant) begin
      mem_addr_o = lk_addr_i;
    end else if (up_grant) begin
      mem_addr_o = up_addr_i;
    end else begin
      mem_addr_o = addr_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_q    <= '0;
      addr_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_tag_q   <= '0;
      upd_count_q <= '0;
    end else begin
      starve_q    <= starve_d;
      addr_q      <= mem_addr_o;
      rsp_valid_q <= lk_grant;
      if (lk_grant) begin
        rsp_tag_q <= lk_tag_i;
      end
      upd_count_q <= upd_count_d;
    end
  end

  assign lk_ready_o  = lk_grant;
  assign up_ready_o  = up_grant;
  assign mem_we_o    = up_grant;
  assign mem_din_o   = up_data_i;
  // RAM output register already lines up with the cycle after the grant.
  assign rsp_data_o  = mem_dout_i;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_tag_o   = rsp_tag_q;
  assign upd_count_o = upd_count_q;

endmodule

// File: tb/tb_hashtable_access_arbiter.sv
module tb_hashtable_access_arbiter;

  localparam int STARVE_LIMIT = 4;

  logic        clk;
  logic        rst;
  logic        lk_valid, lk_ready;
  logic [15:0] lk_addr;
  logic [3:0]  lk_tag;
  logic        rsp_valid;
  logic [11:0] rsp_data;
  logic [3:0]  rsp_tag;
  logic        up_valid, up_ready;
  logic [15:0] up_addr;
  logic [11:0] up_data;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [11:0] mem_din;
  logic [11:0] mem_dout;
  logic [15:0] upd_count;

  hashtable_access_arbiter #(
    .ADDR_W(16), .DATA_W(12), .TAG_W(4), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .lk_valid_i(lk_valid), .lk_ready_o(lk_ready),
    .lk_addr_i(lk_addr), .lk_tag_i(lk_tag),
    .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data), .rsp_tag_o(rsp_tag),
    .up_valid_i(up_valid), .up_ready_o(up_ready),
    .up_addr_i(up_addr), .up_data_i(up_data),
    .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_din_o(mem_din),
    .mem_dout_i(mem_dout), .upd_count_o(upd_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port synchronous-read table
  logic [11:0] ram [0:65535];
  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = '0;
  end
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_din;
    mem_dout <= ram[mem_addr];
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  // Table contents as a sparse map, the number of consecutive cycles the
  // current lookup has lost, the accepted-update total, and the response
  // the next cycle should show.
  logic [11:0] ref_mem [logic [15:0]];
  int          lost      = 0;
  int          cnt       = 0;
  bit          exp_rv    = 0;
  logic [11:0] exp_rd    = '0;
  logic [3:0]  exp_rt    = '0;
  logic [15:0] last_addr = '0;
  bit          g_lk, g_up;
  logic        obs_lr;

  function automatic logic [11:0] ref_rd(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 12'h000;
  endfunction

  // One clock cycle: check what the previous cycle's grant produced, drive
  // new requests, check the grant against the model, advance the model.
  task automatic cycle(input bit r, input bit lv, input logic [15:0] la,
                       input logic [3:0] lt, input bit uv,
                       input logic [15:0] ua, input logic [11:0] ud);
    @(posedge clk); #1;
    chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, exp_rv});
    if (exp_rv) begin
      chk("rsp_data", {20'b0, rsp_data}, {20'b0, exp_rd});
      chk("rsp_tag", {28'b0, rsp_tag}, {28'b0, exp_rt});
    end
    chk("upd_count", {16'b0, upd_count}, cnt);

    rst = r; lk_valid = lv; lk_addr = la; lk_tag = lt;
    up_valid = uv; up_addr = ua; up_data = ud;
    #1;

    g_lk = 0; g_up = 0;
    if (!r) begin
      if (uv && !(lv && lost >= STARVE_LIMIT)) g_up = 1;
      else if (lv) g_lk = 1;
    end
    obs_lr = lk_ready;
    chk("lk_ready", {31'b0, lk_ready}, {31'b0, g_lk});
    chk("up_ready", {31'b0, up_ready}, {31'b0, g_up});
    chk("mem_we", {31'b0, mem_we}, {31'b0, g_up});
    if (g_lk) last_addr = la;
    if (g_up) last_addr = ua;
    chk("mem_addr", {16'b0, mem_addr}, {16'b0, last_addr});
    if (g_up) chk("mem_din", {20'b0, mem_din}, {20'b0, ud});

    exp_rv = g_lk;
    if (g_lk) begin
      exp_rd = ref_rd(la);
      exp_rt = lt;
    end
    if (g_up) begin
      ref_mem[ua] = ud;
      if (cnt < 65535) cnt++;
    end
    lost = (lv && !g_lk) ? lost + 1 : 0;
    if (r) begin
      exp_rv = 0; exp_rt = '0; cnt = 0; lost = 0; last_addr = '0;
    end
  endtask

  task automatic idle();
    cycle(0, 0, 16'h0, 4'h0, 0, 16'h0, 12'h0);
  endtask

  // ---------------- grant table ----------------
  typedef struct {
    logic        rst, lv, uv;
    logic [15:0] la, ua;
    logic [11:0] ud;
    logic        e_lr, e_ur, e_we;
    logic [15:0] e_addr;
  } vec_t;

  vec_t tbl[10];

  bit          lk_pend, up_pend;
  logic [15:0] p_la, p_ua;
  logic [3:0]  p_lt;
  logic [11:0] p_ud;

  initial begin
    tbl[0] = '{1'b1, 1'b1, 1'b1, 16'h1111, 16'h2222, 12'h0AA, 1'b0, 1'b0, 1'b0, 16'h0000};
    tbl[1] = '{1'b0, 1'b0, 1'b0, 16'h3333, 16'h4444, 12'h0BB, 1'b0, 1'b0, 1'b0, 16'h0000};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 16'h1234, 16'h4444, 12'h0BB, 1'b1, 1'b0, 1'b0, 16'h1234};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 16'h5555, 16'h6666, 12'h0CC, 1'b0, 1'b0, 1'b0, 16'h1234};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 16'h5555, 16'h0055, 12'h321, 1'b0, 1'b1, 1'b1, 16'h0055};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 16'h00AA, 16'h00BB, 12'h456, 1'b0, 1'b1, 1'b1, 16'h00BB};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 16'h00AA, 16'h00CC, 12'h789, 1'b0, 1'b0, 1'b0, 16'h00BB};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 16'h0FFF, 16'h00CC, 12'h789, 1'b1, 1'b0, 1'b0, 16'h0FFF};
    tbl[8] = '{1'b1, 1'b1, 1'b1, 16'h0ABC, 16'h0DEF, 12'h111, 1'b0, 1'b0, 1'b0, 16'h0FFF};
    tbl[9] = '{1'b0, 1'b0, 1'b0, 16'h0ABC, 16'h0DEF, 12'h111, 1'b0, 1'b0, 1'b0, 16'h0000};

    rst = 1; lk_valid = 0; up_valid = 0;
    lk_addr = '0; lk_tag = '0; up_addr = '0; up_data = '0;
    repeat (2) @(posedge clk);

    foreach (tbl[i]) begin
      @(posedge clk); #1;
      rst = tbl[i].rst; lk_valid = tbl[i].lv; up_valid = tbl[i].uv;
      lk_addr = tbl[i].la; up_addr = tbl[i].ua; up_data = tbl[i].ud;
      #1;
      chk($sformatf("tbl%0d_lk_ready", i), {31'b0, lk_ready}, {31'b0, tbl[i].e_lr});
      chk($sformatf("tbl%0d_up_ready", i), {31'b0, up_ready}, {31'b0, tbl[i].e_ur});
      chk($sformatf("tbl%0d_mem_we", i), {31'b0, mem_we}, {31'b0, tbl[i].e_we});
      chk($sformatf("tbl%0d_mem_addr", i), {16'b0, mem_addr}, {16'b0, tbl[i].e_addr});
      chk($sformatf("tbl%0d_mem_din", i), {20'b0, mem_din}, {20'b0, tbl[i].ud});
      if (tbl[i].e_ur) ref_mem[tbl[i].ua] = tbl[i].ud;
    end

    // Reset with both requesters asking: nothing may be granted.
    repeat (3) cycle(1, 1, 16'h0010, 4'h1, 1, 16'h0011, 12'h555);
    idle();
    chk("t1_rsp_valid", {31'b0, rsp_valid}, 0);
    chk("t1_rsp_tag", {28'b0, rsp_tag}, 0);
    chk("t1_upd_count", {16'b0, upd_count}, 0);

    // Update then lookup of the same address sees the new entry.
    cycle(0, 0, 16'h0, 4'h0, 1, 16'h0010, 12'h8A5);
    cycle(0, 1, 16'h0010, 4'h3, 0, 16'h0, 12'h0);
    idle();
    chk("t2_rsp_valid", {31'b0, rsp_valid}, 1);
    chk("t2_rsp_data", {20'b0, rsp_data}, 32'h8A5);
    chk("t2_rsp_tag", {28'b0, rsp_tag}, 3);
    chk("t2_upd_count", {16'b0, upd_count}, 1);

    // Four back-to-back lookups.
    for (int a = 1; a <= 4; a++) cycle(0, 0, 16'h0, 4'h0, 1, 16'(a), 12'(32'h100 + a));
    for (int i = 0; i < 6; i++) begin
      cycle(0, i < 4, 16'(i + 1), 4'(i), 0, 16'h0, 12'h0);
      if (i >= 1 && i <= 4) begin
        chk("t3_rsp_valid", {31'b0, rsp_valid}, 1);
        chk("t3_rsp_tag", {28'b0, rsp_tag}, 32'(i - 1));
        chk("t3_rsp_data", {20'b0, rsp_data}, 32'h100 + 32'(i));
      end else if (i == 5) begin
        chk("t3_rsp_end", {31'b0, rsp_valid}, 0);
      end
    end

    // Both requesters held: U,U,U,U,L repeating.
    for (int i = 0; i < 10; i++) begin
      cycle(0, 1, 16'h0003, 4'h9, 1, 16'h0040, 12'(i));
      chk($sformatf("t4_grant%0d", i), {31'b0, obs_lr}, (i % 5 == 4) ? 1 : 0);
    end
    idle();

    // Lookup then update of same address returns the old entry.
    cycle(0, 0, 16'h0, 4'h0, 1, 16'h0020, 12'h123);
    cycle(0, 1, 16'h0020, 4'h5, 0, 16'h0, 12'h0);
    cycle(0, 0, 16'h0, 4'h0, 1, 16'h0020, 12'h7FF);
    chk("t5_old_data", {20'b0, rsp_data}, 32'h123);
    chk("t5_old_tag", {28'b0, rsp_tag}, 5);
    cycle(0, 1, 16'h0020, 4'h6, 0, 16'h0, 12'h0);
    idle();
    chk("t5_new_data", {20'b0, rsp_data}, 32'h7FF);

    // Randomised traffic against the model; requests held until accepted.
    lk_pend = 0; up_pend = 0;
    for (int i = 0; i < 600; i++) begin
      bit r;
      if (!lk_pend && ($urandom_range(2) != 0)) begin
        lk_pend = 1; p_la = 16'($urandom_range(7)); p_lt = 4'($urandom);
      end
      if (!up_pend && ($urandom_range(1) != 0)) begin
        up_pend = 1; p_ua = 16'($urandom_range(7)); p_ud = 12'($urandom);
      end
      r = ($urandom_range(99) == 0);
      cycle(r, lk_pend, lk_pend ? p_la : 16'h0, lk_pend ? p_lt : 4'h0,
            up_pend, up_pend ? p_ua : 16'h0, up_pend ? p_ud : 12'h0);
      if (g_lk) lk_pend = 0;
      if (g_up) up_pend = 0;
    end
    idle();

    // Saturate the update counter.
    for (int i = 0; i < 65540; i++) cycle(0, 0, 16'h0, 4'h0, 1, i[15:0], 12'(i * 7));
    idle();
    chk("t6_saturated", {16'b0, upd_count}, 32'hFFFF);

    // Reset while a lookup is in flight and another is requested.
    cycle(0, 1, 16'h0004, 4'hA, 0, 16'h0, 12'h0);
    cycle(1, 1, 16'h0005, 4'hB, 1, 16'h0006, 12'h333);
    chk("t6_rst_lk_ready", {31'b0, lk_ready}, 0);
    chk("t6_rst_we", {31'b0, mem_we}, 0);
    idle();
    chk("t6_rst_rsp_valid", {31'b0, rsp_valid}, 0);
    chk("t6_rst_upd_count", {16'b0, upd_count}, 0);
    idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
